// File: rtl/conv_linebuf_ctrl.sv
// Line-buffer controller for a 3-row vertical window: streams raster pixels through two
// single-row RAMs and emits one (y-2, y-1, y) column per accepted pixel from row 2 onwards.
module conv_linebuf_ctrl #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  ram0_wr_en,
    output logic [ADDR_WIDTH-1:0] ram0_wr_addr,
    output logic [DATA_WIDTH-1:0] ram0_wr_data,
    output logic [ADDR_WIDTH-1:0] ram0_rd_addr,
    output logic                  ram0_rd_clk_en,
    input  logic [DATA_WIDTH-1:0] ram0_rd_data,
    output logic                  ram1_wr_en,
    output logic [ADDR_WIDTH-1:0] ram1_wr_addr,
    output logic [DATA_WIDTH-1:0] ram1_wr_data,
    output logic [ADDR_WIDTH-1:0] ram1_rd_addr,
    output logic                  ram1_rd_clk_en,
    input  logic [DATA_WIDTH-1:0] ram1_rd_data,
    output logic                  col_valid,
    output logic [DATA_WIDTH-1:0] col_top,
    output logic [DATA_WIDTH-1:0] col_mid,
    output logic [DATA_WIDTH-1:0] col_bot,
    output logic [ADDR_WIDTH-1:0] col_x,
    output logic [11:0]           row_y,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] XLast = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [11:0]           YLast = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] x_q, x_cur, x_s1_q;
    logic [11:0]           y_q, y_cur, y_s1_q;
    logic [DATA_WIDTH-1:0] pix_s1_q;
    logic                  s1_valid_q;
    logic                  accept, last_col, s1_fire, s1_col;

    always_comb begin
        // A frame_start pixel is coordinate (0,0) of the new frame.
        x_cur    = frame_start ? '0 : x_q;
        y_cur    = frame_start ? '0 : y_q;
        accept   = !rst && pix_valid &&
                   (frame_start || state_q == StFill || state_q == StRun);
        last_col = (x_cur == XLast);
        // frame_start cancels whatever stage 1 holds from the previous frame.
        s1_fire  = s1_valid_q && !frame_start;
        s1_col   = s1_fire && (y_s1_q >= 12'd2);

        ram0_rd_clk_en = accept;
        ram1_rd_clk_en = accept;
        ram0_rd_addr   = accept ? x_cur : '0;
        ram1_rd_addr   = accept ? x_cur : '0;

        // Row shift: RAM1's old row moves to RAM0, the new pixel lands in RAM1.
        ram0_wr_en   = s1_fire;
        ram1_wr_en   = s1_fire;
        ram0_wr_addr = s1_fire ? x_s1_q : '0;
        ram1_wr_addr = s1_fire ? x_s1_q : '0;
        ram0_wr_data = s1_fire ? ram1_rd_data : '0;
        ram1_wr_data = s1_fire ? pix_s1_q : '0;

        col_valid  = s1_col;
        col_top    = s1_col ? ram0_rd_data : '0;
        col_mid    = s1_col ? ram1_rd_data : '0;
        col_bot    = s1_col ? pix_s1_q : '0;
        col_x      = s1_col ? x_s1_q : '0;
        row_y      = s1_col ? y_s1_q : '0;
        frame_done = s1_col && (x_s1_q == XLast) && (y_s1_q == YLast);
        busy       = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            s1_valid_q <= 1'b0;
            x_s1_q     <= '0;
            y_s1_q     <= '0;
            pix_s1_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                x_s1_q   <= x_cur;
                y_s1_q   <= y_cur;
                pix_s1_q <= pix_data;
            end

            if (frame_start) begin
                state_q <= StFill;
                x_q     <= '0;
                y_q     <= '0;
            end else if (state_q == StDone) begin
                state_q <= StIdle;
            end

            if (accept) begin
                if (!last_col) begin
                    x_q <= x_cur + ADDR_WIDTH'(1);
                end else begin
                    x_q <= '0;
                    if (y_cur == YLast) begin
                        y_q     <= '0;
                        state_q <= StDone;
                    end else begin
                        y_q <= y_cur + 12'd1;
                        if (y_cur == 12'd1) state_q <= StRun;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_linebuf_ctrl.sv
// Bench for conv_linebuf_ctrl: a 4x4 instance with RAM models and a column scoreboard,
// plus a 512-wide instance exercising the full address range.
module tb_conv_linebuf_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int BW = 512;
    localparam int BH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixf(input int x, input int y);
        return 8'((x * 3 + y * 85) & 255);
    endfunction

    // ---------------- 4x4 instance ----------------
    logic       rst = 1'b0;
    logic       frame_start = 1'b0, pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic       ram0_wr_en, ram0_rd_clk_en, ram1_wr_en, ram1_rd_clk_en;
    logic [8:0] ram0_wr_addr, ram0_rd_addr, ram1_wr_addr, ram1_rd_addr;
    logic [7:0] ram0_wr_data, ram1_wr_data;
    logic [7:0] ram0_rd_data = 8'd0, ram1_rd_data = 8'd0;
    logic       col_valid, frame_done, busy;
    logic [7:0] col_top, col_mid, col_bot;
    logic [8:0] col_x;
    logic [11:0] row_y;

    conv_linebuf_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_data(pix_data),
        .ram0_wr_en(ram0_wr_en), .ram0_wr_addr(ram0_wr_addr), .ram0_wr_data(ram0_wr_data),
        .ram0_rd_addr(ram0_rd_addr), .ram0_rd_clk_en(ram0_rd_clk_en),
        .ram0_rd_data(ram0_rd_data),
        .ram1_wr_en(ram1_wr_en), .ram1_wr_addr(ram1_wr_addr), .ram1_wr_data(ram1_wr_data),
        .ram1_rd_addr(ram1_rd_addr), .ram1_rd_clk_en(ram1_rd_clk_en),
        .ram1_rd_data(ram1_rd_data),
        .col_valid(col_valid), .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
        .col_x(col_x), .row_y(row_y), .frame_done(frame_done), .busy(busy)
    );

    logic [7:0] mem0 [0:511];
    logic [7:0] mem1 [0:511];
    always @(posedge clk) begin
        if (ram0_wr_en) mem0[ram0_wr_addr] <= ram0_wr_data;
        if (ram1_wr_en) mem1[ram1_wr_addr] <= ram1_wr_data;
        if (ram0_rd_clk_en) ram0_rd_data <= mem0[ram0_rd_addr];
        if (ram1_rd_clk_en) ram1_rd_data <= mem1[ram1_rd_addr];
    end

    typedef struct packed {
        logic [7:0]  top;
        logic [7:0]  mid;
        logic [7:0]  bot;
        logic [8:0]  x;
        logic [11:0] y;
        logic        done;
        logic [31:0] cyc;
    } col_t;

    col_t q[$];
    col_t e;
    logic [7:0] img [0:H-1][0:W-1];
    int bx = 0, by = 0;
    bit active = 1'b0;
    int wr_cnt = 0, done_cnt = 0, w0 = 0;

    // Drive one cycle of stimulus and update the reference model.
    task automatic send_a(input logic fs, input logic pv, input logic [7:0] pix);
        @(posedge clk);
        #1;
        frame_start = fs;
        pix_valid   = pv;
        pix_data    = pix;
        if (fs) begin
            while (q.size() > 0 && q[$].cyc == 32'(cyc)) void'(q.pop_back());
            bx = 0;
            by = 0;
            active = 1'b1;
        end
        if (pv && active) begin
            img[by][bx] = pix;
            if (by >= 2)
                q.push_back('{top: img[by-2][bx], mid: img[by-1][bx], bot: pix,
                              x: 9'(bx), y: 12'(by), done: (bx == W-1 && by == H-1),
                              cyc: 32'(cyc + 1)});
            if (bx == W-1) begin
                bx = 0;
                if (by == H-1) active = 1'b0;
                else by++;
            end else begin
                bx++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (ram1_wr_en) wr_cnt++;
        if (frame_done) begin
            done_cnt++;
            check("done_with_col", 128'(col_valid), 128'(1));
        end
        if (col_valid) begin
            if (q.size() == 0) begin
                check("col_unexpected", 128'(col_valid), 128'(0));
            end else begin
                e = q.pop_front();
                check("col", 128'({col_top, col_mid, col_bot, col_x, row_y, frame_done}),
                      128'({e.top, e.mid, e.bot, e.x, e.y, e.done}));
                check("col_latency", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // ---------------- 512-wide instance ----------------
    logic       b_fs = 1'b0, b_pv = 1'b0;
    logic [7:0] b_pix = 8'd0;
    logic       b_ram0_wr_en, b_ram0_rd_clk_en, b_ram1_wr_en, b_ram1_rd_clk_en;
    logic [8:0] b_ram0_wr_addr, b_ram0_rd_addr, b_ram1_wr_addr, b_ram1_rd_addr;
    logic [7:0] b_ram0_wr_data, b_ram1_wr_data;
    logic [7:0] b_ram0_rd_data = 8'd0, b_ram1_rd_data = 8'd0;
    logic       b_col_valid, b_frame_done, b_busy;
    logic [7:0] b_col_top, b_col_mid, b_col_bot;
    logic [8:0] b_col_x;
    logic [11:0] b_row_y;

    conv_linebuf_ctrl #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_WIDTH(8), .ADDR_WIDTH(9)) dut_b (
        .clk(clk), .rst(rst), .frame_start(b_fs), .pix_valid(b_pv), .pix_data(b_pix),
        .ram0_wr_en(b_ram0_wr_en), .ram0_wr_addr(b_ram0_wr_addr),
        .ram0_wr_data(b_ram0_wr_data), .ram0_rd_addr(b_ram0_rd_addr),
        .ram0_rd_clk_en(b_ram0_rd_clk_en), .ram0_rd_data(b_ram0_rd_data),
        .ram1_wr_en(b_ram1_wr_en), .ram1_wr_addr(b_ram1_wr_addr),
        .ram1_wr_data(b_ram1_wr_data), .ram1_rd_addr(b_ram1_rd_addr),
        .ram1_rd_clk_en(b_ram1_rd_clk_en), .ram1_rd_data(b_ram1_rd_data),
        .col_valid(b_col_valid), .col_top(b_col_top), .col_mid(b_col_mid),
        .col_bot(b_col_bot), .col_x(b_col_x), .row_y(b_row_y),
        .frame_done(b_frame_done), .busy(b_busy)
    );

    logic [7:0] bmem0 [0:511];
    logic [7:0] bmem1 [0:511];
    always @(posedge clk) begin
        if (b_ram0_wr_en) bmem0[b_ram0_wr_addr] <= b_ram0_wr_data;
        if (b_ram1_wr_en) bmem1[b_ram1_wr_addr] <= b_ram1_wr_data;
        if (b_ram0_rd_clk_en) b_ram0_rd_data <= bmem0[b_ram0_rd_addr];
        if (b_ram1_rd_clk_en) b_ram1_rd_data <= bmem1[b_ram1_rd_addr];
    end

    int b_col_cnt = 0, b_done_cnt = 0;
    always @(negedge clk) begin
        if (b_frame_done) b_done_cnt++;
        if (b_col_valid) begin
            check("b_col", 128'({b_col_top, b_col_mid, b_col_bot, b_col_x, b_row_y,
                                 b_frame_done}),
                  128'({pixf(b_col_cnt, 0), pixf(b_col_cnt, 1), pixf(b_col_cnt, 2),
                        9'(b_col_cnt), 12'd2, (b_col_cnt == BW-1)}));
            b_col_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 8'hEE; mem1[i] = 8'hEE; bmem0[i] = 8'hEE; bmem1[i] = 8'hEE;
        end

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", 128'({ram0_wr_en, ram0_wr_addr, ram0_wr_data, ram0_rd_addr,
              ram0_rd_clk_en, ram1_wr_en, ram1_wr_addr, ram1_wr_data, ram1_rd_addr,
              ram1_rd_clk_en, col_valid, col_top, col_mid, col_bot, col_x, row_y,
              frame_done, busy}), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Continuous frame, then two stray pixels that must be dropped
        w0 = wr_cnt;
        send_a(1'b1, 1'b0, 8'd0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send_a(1'b0, 1'b1, 8'(16 * y + x));
                if (x == 0 && y == 0) check("busy_fill", 128'(busy), 128'(1));
            end
        send_a(1'b0, 1'b1, 8'h55);
        send_a(1'b0, 1'b1, 8'h56);
        repeat (3) send_a(1'b0, 1'b0, 8'd0);
        check("frame1_writes", 128'(wr_cnt - w0), 128'(16));
        check("frame1_done", 128'(done_cnt), 128'(1));
        check("frame1_idle", 128'(busy), 128'(0));
        check("frame1_q_empty", 128'(q.size()), 128'(0));

        // Same frame with 3-cycle gaps after every pixel
        w0 = wr_cnt;
        send_a(1'b1, 1'b0, 8'd0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                send_a(1'b0, 1'b1, 8'(16 * y + x));
                repeat (3) send_a(1'b0, 1'b0, 8'd0);
            end
        repeat (2) send_a(1'b0, 1'b0, 8'd0);
        check("frame2_writes", 128'(wr_cnt - w0), 128'(16));
        check("frame2_done", 128'(done_cnt), 128'(2));
        check("frame2_q_empty", 128'(q.size()), 128'(0));

        // Restart after 6 pixels; the 6th pixel's stage-1 write is cancelled
        w0 = wr_cnt;
        send_a(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) send_a(1'b0, 1'b1, 8'(16 * (i / W) + (i % W)));
        send_a(1'b1, 1'b0, 8'd0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) send_a(1'b0, 1'b1, 8'(8'h80 + 16 * y + x));
        repeat (3) send_a(1'b0, 1'b0, 8'd0);
        check("restart_writes", 128'(wr_cnt - w0), 128'(21));
        check("restart_done", 128'(done_cnt), 128'(3));
        check("restart_q_empty", 128'(q.size()), 128'(0));

        // frame_start together with a pixel
        send_a(1'b1, 1'b1, 8'hAA);
        send_a(1'b0, 1'b0, 8'd0);
        @(negedge clk);
        check("aa_write", 128'({ram1_wr_en, ram1_wr_addr, ram1_wr_data}),
              128'({1'b1, 9'd0, 8'hAA}));
        while (!(by == 2 && bx == 2)) send_a(1'b0, 1'b1, 8'(16 * by + bx));

        // Reset mid-row 2 while a column is in flight
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        q.delete();
        active = 1'b0;
        w0 = wr_cnt;
        #1;
        check("midrst_outputs", 128'({ram0_wr_en, ram0_wr_addr, ram0_wr_data, ram0_rd_addr,
              ram0_rd_clk_en, ram1_wr_en, ram1_wr_addr, ram1_wr_data, ram1_rd_addr,
              ram1_rd_clk_en, col_valid, col_top, col_mid, col_bot, col_x, row_y,
              frame_done, busy}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) send_a(1'b0, 1'b1, 8'h77);
        repeat (2) send_a(1'b0, 1'b0, 8'd0);
        check("postrst_no_writes", 128'(wr_cnt - w0), 128'(0));
        check("postrst_idle", 128'(busy), 128'(0));
        check("postrst_done", 128'(done_cnt), 128'(3));

        // Full-width frame on the 512-wide instance
        @(posedge clk);
        #1 b_fs = 1'b1;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) begin
                @(posedge clk);
                #1;
                b_fs  = 1'b0;
                b_pv  = 1'b1;
                b_pix = pixf(x, y);
            end
        @(posedge clk);
        #1 b_pv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b_col_count", 128'(b_col_cnt), 128'(BW));
        check("b_done_count", 128'(b_done_cnt), 128'(1));
        check("b_idle", 128'(b_busy), 128'(0));

        check("final_q_empty", 128'(q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
